divider: RTL and testbench

Sequential unsigned restoring divider for the datapath, built around repeated N+1-bit subtraction. It is the iterative inverse of the combinational adder block. A single-cycle start pulse launches an operation. The block produces one quotient bit per clock and presents registered quotient and remainder with a one-cycle done pulse. It sits beside the adder/ALU and serves multi-cycle divide instructions.

---
 rtl/divider_if.sv | 27 ++
 rtl/divider.sv | 119 +++++++++++
 tb/tb_divider.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Operand/result bundle between the divider and whoever issues divide
// requests. The requester owns start and the operands; the divider owns
// the status flags and the registered results.
interface divider_if #(
    parameter int N = 8
);

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/divider.sv
// Sequential unsigned restoring divider. A start accepted while idle (or in
// the one-cycle DONE state) launches N shift/subtract steps, one quotient
// bit per clock, followed by a one-cycle done pulse with registered results.
// A zero divisor skips iteration and reports all-ones quotient, the dividend
// as remainder and the div_by_zero flag.
module divider #(
    parameter int N = 8
) (
    input  logic     clk,
    input  logic     reset,
    divider_if.slave bus
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e        state_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  quotient_q;
    logic [N-1:0]  remainder_q;
    logic          divByZero_q;
    logic [CW-1:0] count_q;

    // Partial remainder is held in N bits: after every step it is below the
    // divisor, so its (N+1)th bit is always zero and only exists while the
    // shifted value is being compared against the divisor.
    logic [N-1:0]  partRem_q;
    logic [N-1:0]  partRem_d;
    logic [N-1:0]  quotShift_q;
    logic [N-1:0]  quotShift_d;
    logic [N-1:0]  divisor_q;

    logic [N:0]    shifted;
    logic [N:0]    diff;

    // One restoring step: shift {R,Q} left, trial-subtract D at N+1 bits and
    // keep the difference only when it did not go negative.
    always_comb begin
        shifted     = {partRem_q, quotShift_q[N-1]};
        diff        = shifted + ~{1'b0, divisor_q} + (N+1)'(1);
        partRem_d   = shifted[N-1:0];
        quotShift_d = {quotShift_q[N-2:0], 1'b0};
        if (!diff[N]) begin
            partRem_d   = diff[N-1:0];
            quotShift_d = {quotShift_q[N-2:0], 1'b1};
        end
    end

    // Control FSM with registered status flags and result registers; reset
    // wins over everything, including a start in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
            count_q     <= '0;
            partRem_q   <= '0;
            quotShift_q <= '0;
            divisor_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            quotShift_q <= bus.dividend;
                            divisor_q   <= bus.divisor;
                            partRem_q   <= '0;
                            count_q     <= CW'(N);
                            busy_q      <= 1'b1;
                            state_q     <= RUN;
                        end else begin
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend;
                            divByZero_q <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                RUN: begin
                    partRem_q   <= partRem_d;
                    quotShift_q <= quotShift_d;
                    count_q     <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        quotient_q  <= quotShift_d;
                        remainder_q <= partRem_d;
                        divByZero_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = divByZero_q;

endmodule

// File: tb/tb_divider.sv
// Testbench for the restoring divider: directed timing/boundary cases plus
// randomized operands, with results checked through an expected-value queue.
module tb_divider;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;

    int errorCount = 0;
    int checkCount = 0;
    bit monitorOn  = 1'b0;

    typedef struct {
        int dvd;
        int dvs;
        int quot;
        int rem;
        int dbz;
    } expT;

    expT sb[$];

    divider_if #(.N(N)) bus ();

    divider #(.N(N)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    // Drives one start pulse; call just after a rising edge. Returns one
    // time unit after the edge that sampled start, i.e. in cycle 1.
    task automatic applyStimulus(input int dvd, input int dvs, input bit track);
        expT e;
        bus.start    = 1'b1;
        bus.dividend = dvd[N-1:0];
        bus.divisor  = dvs[N-1:0];
        if (track) begin
            e.dvd = dvd;
            e.dvs = dvs;
            if (dvs == 0) begin
                e.quot = (1 << N) - 1;
                e.rem  = dvd;
                e.dbz  = 1;
            end else begin
                e.quot = dvd / dvs;
                e.rem  = dvd % dvs;
                e.dbz  = 0;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Full operation with per-cycle busy/done checks up to one cycle past done.
    task automatic runAndCheck(input int dvd, input int dvs);
        int doneCycle;
        doneCycle = (dvs == 0) ? 1 : N + 1;
        applyStimulus(dvd, dvs, 1'b1);
        for (int c = 1; c <= doneCycle + 1; c++) begin
            @(negedge clk);
            checkOutput($sformatf("busy %0d/%0d c%0d", dvd, dvs, c), int'(bus.busy),
                        int'(dvs != 0 && c <= N));
            checkOutput($sformatf("done %0d/%0d c%0d", dvd, dvs, c), int'(bus.done),
                        int'(c == doneCycle));
        end
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for done; the cycle it appears in is compared.
    task automatic waitDone(input int fromCycle, input int expCycle, input string tag);
        int seen;
        seen = -1;
        for (int c = fromCycle; c < fromCycle + 3 * N; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = c;
                break;
            end
        end
        checkOutput(tag, seen, expCycle);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every done pops the oldest expectation and compares.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("busyDoneExclusive", int'(bus.busy && bus.done), 0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedDone", 1, 0);
                end else begin : popBlk
                    expT e;
                    e = sb.pop_front();
                    checkOutput($sformatf("quot %0d/%0d", e.dvd, e.dvs), int'(bus.quotient), e.quot);
                    checkOutput($sformatf("rem %0d/%0d", e.dvd, e.dvs), int'(bus.remainder), e.rem);
                    checkOutput($sformatf("dbz %0d/%0d", e.dvd, e.dvs), int'(bus.div_by_zero), e.dbz);
                    if (e.dvs != 0) begin
                        checkOutput($sformatf("invariant %0d/%0d", e.dvd, e.dvs),
                                    int'(bus.quotient) * e.dvs + int'(bus.remainder), e.dvd);
                        checkOutput($sformatf("remLtDiv %0d/%0d", e.dvd, e.dvs),
                                    int'(int'(bus.remainder) < e.dvs), 1);
                    end
                end
            end
        end
    end

    initial begin
        int dvd;
        int dvs;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        checkOutput("rstBusy", int'(bus.busy), 0);
        checkOutput("rstDone", int'(bus.done), 0);
        checkOutput("rstQuot", int'(bus.quotient), 0);
        checkOutput("rstRem", int'(bus.remainder), 0);
        checkOutput("rstDbz", int'(bus.div_by_zero), 0);
        monitorOn = 1'b1;
        @(posedge clk);
        #1;

        runAndCheck(100, 7);
        runAndCheck(255, 1);
        runAndCheck(5, 200);
        runAndCheck(255, 255);
        runAndCheck(37, 0);

        // Start during RUN must be ignored; the first result arrives unchanged.
        applyStimulus(100, 7, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(5, N + 1, "ignoredStartDoneCycle");

        // Reset in cycle 5 aborts; a start alongside it is ignored.
        applyStimulus(100, 7, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy", int'(bus.busy), 0);
        checkOutput("abortDone", int'(bus.done), 0);
        checkOutput("abortQuot", int'(bus.quotient), 0);
        checkOutput("abortRem", int'(bus.remainder), 0);
        checkOutput("abortDbz", int'(bus.div_by_zero), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abortStartIgnored", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        runAndCheck(50, 6);

        // Back-to-back: new start in the DONE cycle, old result held meanwhile.
        applyStimulus(100, 7, 1'b1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        checkOutput("b2bFirstDone", int'(bus.done), 1);
        applyStimulus(200, 9, 1'b1);
        for (int c = 10; c <= 17; c++) begin
            @(negedge clk);
            checkOutput($sformatf("b2bBusy c%0d", c), int'(bus.busy), 1);
            checkOutput($sformatf("b2bHoldQuot c%0d", c), int'(bus.quotient), 14);
            checkOutput($sformatf("b2bHoldRem c%0d", c), int'(bus.remainder), 2);
        end
        waitDone(18, 18, "b2bSecondDoneCycle");

        // Randomized operands; a zero divisor shows up occasionally.
        repeat (1000) begin
            dvd = int'($urandom_range(0, (1 << N) - 1));
            dvs = int'($urandom_range(0, (1 << N) - 1));
            applyStimulus(dvd, dvs, 1'b1);
            waitDone(1, (dvs == 0) ? 1 : N + 1, $sformatf("randLatency %0d/%0d", dvd, dvs));
        end

        checkOutput("sbDrained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
